// File: rtl/cpu_pkg.sv
// Shared fetch-front-end definitions: FSM states, fault causes and default vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_TRAP     = 2'b01,
        FAULT_MISALIGN = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0080;
    localparam int unsigned DEFAULT_TIMEOUT   = 16;
    localparam int unsigned WAIT_CNT_W        = 8;

    function automatic logic pc_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// Architectural fetch PC register; loads the externally selected next PC when enabled.
module pc_fetch_ctrl_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] next_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (load_i) begin
            pc_q <= next_pc_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: issues imem requests, sequences the PC, and handles
// redirects, traps, stale-response squashing and fetch timeouts.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] current_pc,
    output logic [1:0]  fault
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    fetch_state_e          state_q, state_d;
    fault_e                fault_q, fault_d;
    logic                  pend_q, pend_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  valid_q;
    logic [31:0]           inst_q, inst_pc_q;

    logic        req;
    logic        starving;
    logic        timeout_hit;
    logic        deliver;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] pc_cur;

    // A pending request keeps imem_req high through stall so the address stays stable.
    assign req         = (state_q == ST_FETCH) && (!stall || pend_q);
    assign starving    = req && !imem_ready;
    assign timeout_hit = starving && (wait_q == WAIT_LAST);
    assign deliver     = req && imem_ready && !trap && !redirect_valid;

    always_comb begin
        pc_load = 1'b1;
        pc_next = pc_cur;
        fault_d = fault_q;
        if (trap) begin
            pc_next = TRAP_VEC;
            fault_d = FAULT_TRAP;
        end else if (timeout_hit) begin
            pc_next = TRAP_VEC;
            fault_d = FAULT_TIMEOUT;
        end else if (redirect_valid) begin
            if (pc_aligned(redirect_pc[1:0])) begin
                pc_next = redirect_pc;
            end else begin
                pc_next = TRAP_VEC;
                fault_d = FAULT_MISALIGN;
            end
        end else if (deliver) begin
            pc_next = pc_cur + 32'd4;
            fault_d = FAULT_NONE;
        end else begin
            pc_load = 1'b0;
        end
    end

    // BOOT also serves as the single idle cycle that follows a timeout.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        wait_d  = '0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (trap) begin
                    state_d = starving ? ST_KILL : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_BOOT;
                end else if (redirect_valid) begin
                    state_d = starving ? ST_KILL : ST_FETCH;
                end else if (starving) begin
                    pend_d = 1'b1;
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_KILL: begin
                if (imem_ready || (!trap && !redirect_valid && wait_q == WAIT_LAST)) begin
                    state_d = ST_FETCH;
                end else if (!trap && !redirect_valid) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            fault_q   <= FAULT_NONE;
            pend_q    <= 1'b0;
            wait_q    <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            valid_q <= deliver;
            if (deliver) begin
                inst_q    <= imem_rdata;
                inst_pc_q <= pc_cur;
            end
        end
    end

    pc_fetch_ctrl_pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (pc_load),
        .next_pc_i (pc_next),
        .pc_o      (pc_cur)
    );

    assign imem_req   = req;
    assign imem_addr  = pc_cur;
    assign current_pc = pc_cur;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0080;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, trap = 1'b0, imem_ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'h0;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc, current_pc;
    logic [1:0]  fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .RESET_VEC (RV),
        .TRAP_VEC  (TV),
        .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .current_pc     (current_pc),
        .fault          (fault)
    );

    // Reference model: idle = cycle with no fetch allowed, drop = a stale response is owed.
    logic [31:0] m_pc, m_inst, m_inst_pc;
    logic [1:0]  m_fault;
    bit          m_valid, m_idle, m_drop, m_pending;
    int unsigned m_wait;

    function automatic bit m_req();
        return !m_idle && !m_drop && (!stall || m_pending);
    endfunction

    task automatic model_reset();
        m_pc = RV; m_inst = 32'h0; m_inst_pc = 32'h0; m_fault = 2'b00;
        m_valid = 1'b0; m_idle = 1'b1; m_drop = 1'b0; m_pending = 1'b0; m_wait = 0;
    endtask

    task automatic model_step();
        bit req, starve, tmo, take, was_idle, was_drop;
        req      = m_req();
        starve   = req && !imem_ready;
        tmo      = starve && (m_wait + 1 == TMO);
        take     = req && imem_ready && !trap && !redirect_valid;
        was_idle = m_idle;
        was_drop = m_drop;
        m_valid  = take;
        if (take) begin
            m_inst = imem_rdata;
            m_inst_pc = m_pc;
        end
        if (trap) begin
            m_pc = TV; m_fault = 2'b01;
        end else if (tmo) begin
            m_pc = TV; m_fault = 2'b11;
        end else if (redirect_valid) begin
            if (redirect_pc % 4 != 0) begin
                m_pc = TV; m_fault = 2'b10;
            end else begin
                m_pc = redirect_pc;
            end
        end else if (take) begin
            m_pc = m_pc + 32'd4; m_fault = 2'b00;
        end
        m_idle = 1'b0;
        m_pending = 1'b0;
        if (was_idle) begin
            m_wait = 0;
        end else if (was_drop) begin
            if (imem_ready) begin
                m_drop = 1'b0; m_wait = 0;
            end else if (trap || redirect_valid) begin
                m_wait = 0;
            end else if (m_wait + 1 == TMO) begin
                m_drop = 1'b0; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else if (trap || (redirect_valid && !tmo)) begin
            m_drop = starve; m_wait = 0;
        end else if (tmo) begin
            m_idle = 1'b1; m_wait = 0;
        end else if (starve) begin
            m_pending = 1'b1; m_wait++;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic tp, input logic rdy, input logic [31:0] rd);
        stall = st; redirect_valid = rv; redirect_pc = rpc; trap = tp;
        imem_ready = rdy; imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst, inst_pc); end
        checks++; if (current_pc !== RV || fault !== 2'b00) begin failures++; $display("FAIL reset_pc_fault got=%h/%b exp=%h/00", current_pc, fault, RV); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1);
        checks++; if (imem_req !== 1'b0 || imem_addr !== RV) begin failures++; $display("FAIL boot_cycle got req=%b addr=%h exp req=0 addr=%h", imem_req, imem_addr, RV); end
        tick();
    endtask

    task automatic test_boot_sequence();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_idle_req got=%b exp=0", imem_req); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1001);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL boot_first got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, inst_valid); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1002);
        checks++; if (imem_addr !== 32'h4 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1001) begin failures++; $display("FAIL boot_second got addr=%h v=%b pc=%h inst=%h exp 4/1/0/1001", imem_addr, inst_valid, inst_pc, inst); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h1002) begin failures++; $display("FAIL boot_third got addr=%h v=%b pc=%h inst=%h exp 8/1/4/1002", imem_addr, inst_valid, inst_pc, inst); end
        tick();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL redir_hold got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0 || current_pc !== 32'h100) begin failures++; $display("FAIL redir_kill got req=%b pc=%h exp 0/100", imem_req, current_pc); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_drop got v=%b req=%b addr=%h exp 0/1/100", inst_valid, imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h1234 || inst_pc !== 32'h100 || current_pc !== 32'h104) begin failures++; $display("FAIL redir_fetch got v=%b inst=%h ipc=%h pc=%h exp 1/1234/100/104", inst_valid, inst, inst_pc, current_pc); end
        tick();
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0);
        checks++; if (current_pc !== TV || fault !== 2'b10 || imem_req !== 1'b0) begin failures++; $display("FAIL misalign_load got pc=%h fault=%b req=%b exp 80/10/0", current_pc, fault, imem_req); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555);
        checks++; if (imem_req !== 1'b1 || imem_addr !== TV) begin failures++; $display("FAIL misalign_addr got req=%b addr=%h exp 1/80", imem_req, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== TV || inst !== 32'h5555 || fault !== 2'b00) begin failures++; $display("FAIL misalign_deliver got v=%b ipc=%h inst=%h fault=%b exp 1/80/5555/00", inst_valid, inst_pc, inst, fault); end
        tick();
    endtask

    task automatic test_timeout();
        int bad = 0;
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < int'(TMO); k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL timeout_wait got bad_cycles=%0d exp 0", bad); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0 || current_pc !== TV || fault !== 2'b11) begin failures++; $display("FAIL timeout_idle got req=%b pc=%h fault=%b exp 0/80/11", imem_req, current_pc, fault); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== TV) begin failures++; $display("FAIL timeout_resume got req=%b addr=%h exp 1/80", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_trap_redirect_stall();
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", imem_req); end
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (current_pc !== TV || fault !== 2'b01 || imem_req !== 1'b0) begin failures++; $display("FAIL trap_prio got pc=%h fault=%b req=%b exp 80/01/0", current_pc, fault, imem_req); end
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9);
        checks++; if (current_pc !== TV || inst_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold got pc=%h v=%b req=%b exp 80/0/0", current_pc, inst_valid, imem_req); end
        tick();
    endtask

    task automatic test_stall_outstanding();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL stall_keep got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h77 || imem_req !== 1'b0 || current_pc !== 32'h4) begin failures++; $display("FAIL stall_done got v=%b inst=%h req=%b pc=%h exp 1/77/0/4", inst_valid, inst, imem_req, current_pc); end
        tick();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAB);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_addr got addr=%h req=%b exp fffffffc/1", imem_addr, imem_req); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got v=%b ipc=%h addr=%h exp 1/fffffffc/0", inst_valid, inst_pc, imem_addr); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || current_pc !== RV || fault !== 2'b00) begin failures++; $display("FAIL midfetch_reset got req=%b v=%b inst=%h ipc=%h pc=%h fault=%b exp all zero", imem_req, inst_valid, inst, inst_pc, current_pc, fault); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL post_reset_boot got req=%b v=%b exp 0/0", imem_req, inst_valid); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RV) begin failures++; $display("FAIL post_reset_stale got v=%b req=%b addr=%h exp 0/1/0", inst_valid, imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_random();
        int drought = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic st, rv, tp, rdy;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 99) < 25);
            rv  = ($urandom_range(0, 99) < 8);
            tp  = ($urandom_range(0, 99) < 3);
            rpc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF0;
            if (drought == 0 && $urandom_range(0, 99) < 3) drought = $urandom_range(10, 25);
            if (drought > 0) begin
                rdy = 1'b0; st = 1'b0; rv = 1'b0; tp = 1'b0;
                drought--;
            end else begin
                rdy = ($urandom_range(0, 99) < 45);
            end
            drive(st, rv, rpc, tp, rdy, $urandom);
            checks++; if (imem_req !== m_req()) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req, m_req()); end
            checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_addr, m_pc); end
            checks++; if (current_pc !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, current_pc, m_pc); end
            checks++; if (inst_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, inst_valid, m_valid); end
            checks++; if (inst !== m_inst) begin failures++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", i, inst, m_inst); end
            checks++; if (inst_pc !== m_inst_pc) begin failures++; $display("FAIL rnd_inst_pc cyc=%0d got=%h exp=%h", i, inst_pc, m_inst_pc); end
            checks++; if (fault !== m_fault) begin failures++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", i, fault, m_fault); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_boot_sequence();
        test_redirect_wait();
        test_misaligned();
        test_timeout();
        test_trap_redirect_stall();
        test_stall_outstanding();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
